// File: rtl/pipe_dest_tracker_if.sv
// Hazard-interface bundle between the ID/EXE control path and pipe_dest_tracker.
// The master side drives ID-stage tags and pipeline events; the slave side returns stage tags and controls.
interface pipe_dest_tracker_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic                       id_valid;
    logic [REG_AW-1:0]          id_dest;
    logic                       id_wb_enable;
    logic                       id_mem_read;
    logic [REG_AW-1:0]          id_src1;
    logic [REG_AW-1:0]          id_src2;
    logic                       id_two_src;
    logic                       hazard;
    logic                       branch_taken;
    logic                       mem_ready;
    logic [REG_AW-1:0]          exec_dest;
    logic                       exec_wb_enable;
    logic                       exec_mem_read;
    logic [REG_AW-1:0]          mem_dest;
    logic                       mem_wb_enable;
    logic [REG_AW-1:0]          wb_dest;
    logic                       wb_wb_enable;
    logic                       freeze_if_id;
    logic                       flush_if_id;
    logic                       load_use;
    logic [(1<<REG_AW)-1:0]     pending;
    logic [CNT_W-1:0]           stall_cycles;

    modport master (
        output id_valid, id_dest, id_wb_enable, id_mem_read, id_src1, id_src2, id_two_src,
               hazard, branch_taken, mem_ready,
        input  exec_dest, exec_wb_enable, exec_mem_read, mem_dest, mem_wb_enable,
               wb_dest, wb_wb_enable, freeze_if_id, flush_if_id, load_use, pending, stall_cycles
    );

    modport slave (
        input  id_valid, id_dest, id_wb_enable, id_mem_read, id_src1, id_src2, id_two_src,
               hazard, branch_taken, mem_ready,
        output exec_dest, exec_wb_enable, exec_mem_read, mem_dest, mem_wb_enable,
               wb_dest, wb_wb_enable, freeze_if_id, flush_if_id, load_use, pending, stall_cycles
    );
endinterface

// File: rtl/pipe_dest_tracker.sv
// Carries destination tags through EXE/MEM/WB, raises IF/ID freeze/flush,
// detects load-use stalls and keeps a per-register pending mask plus a stall counter.
module pipe_dest_tracker #(
    parameter int REG_AW = 4,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_dest_tracker_if.slave bus
);
    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_FLUSH,
        ACT_STALL,
        ACT_ADVANCE
    } action_t;

    action_t            action;
    logic               exe_valid, exe_wb, exe_mr;
    logic [REG_AW-1:0]  exe_dest;
    logic               mem_valid, mem_wb;
    logic [REG_AW-1:0]  mem_dest_q;
    logic               wb_valid, wb_wb;
    logic [REG_AW-1:0]  wb_dest_q;
    logic [CNT_W-1:0]   stall_q;
    logic               load_use_c;
    logic               freeze_c;
    logic               flush_c;
    logic [(1<<REG_AW)-1:0] pending_c;

    always_comb begin
        load_use_c = (FWD_EN != 0) && exe_valid && exe_mr && bus.id_valid &&
                     ((exe_dest == bus.id_src1) ||
                      (bus.id_two_src && (exe_dest == bus.id_src2)));
    end

    always_comb begin
        action = ACT_ADVANCE;
        if (!bus.mem_ready)
            action = ACT_HOLD;
        else if (bus.branch_taken)
            action = ACT_FLUSH;
        else if (bus.hazard || load_use_c)
            action = ACT_STALL;
    end

    // Gated by rst_n so that every output reads 0 while reset is asserted.
    always_comb begin
        freeze_c = rst_n && ((action == ACT_HOLD) || (action == ACT_STALL));
        flush_c  = rst_n && (action == ACT_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid  <= 1'b0;
            exe_dest   <= '0;
            exe_wb     <= 1'b0;
            exe_mr     <= 1'b0;
            mem_valid  <= 1'b0;
            mem_dest_q <= '0;
            mem_wb     <= 1'b0;
            wb_valid   <= 1'b0;
            wb_dest_q  <= '0;
            wb_wb      <= 1'b0;
            stall_q    <= '0;
        end else begin
            if (action != ACT_HOLD) begin
                mem_valid  <= exe_valid;
                mem_dest_q <= exe_dest;
                mem_wb     <= exe_wb;
                wb_valid   <= mem_valid;
                wb_dest_q  <= mem_dest_q;
                wb_wb      <= mem_wb;
                // An invalid ID slot enters EXE as a bubble with cleared fields.
                if (action == ACT_ADVANCE && bus.id_valid) begin
                    exe_valid <= 1'b1;
                    exe_dest  <= bus.id_dest;
                    exe_wb    <= bus.id_wb_enable;
                    exe_mr    <= bus.id_mem_read;
                end else begin
                    exe_valid <= 1'b0;
                    exe_dest  <= '0;
                    exe_wb    <= 1'b0;
                    exe_mr    <= 1'b0;
                end
            end
            if (freeze_c && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    always_comb begin
        pending_c = '0;
        if (exe_valid && exe_wb) pending_c[exe_dest]   = 1'b1;
        if (mem_valid && mem_wb) pending_c[mem_dest_q] = 1'b1;
        if (wb_valid && wb_wb)   pending_c[wb_dest_q]  = 1'b1;
    end

    assign bus.exec_dest      = exe_dest;
    assign bus.exec_wb_enable = exe_valid & exe_wb;
    assign bus.exec_mem_read  = exe_valid & exe_mr;
    assign bus.mem_dest       = mem_dest_q;
    assign bus.mem_wb_enable  = mem_valid & mem_wb;
    assign bus.wb_dest        = wb_dest_q;
    assign bus.wb_wb_enable   = wb_valid & wb_wb;
    assign bus.freeze_if_id   = freeze_c;
    assign bus.flush_if_id    = flush_c;
    assign bus.load_use       = load_use_c;
    assign bus.pending        = pending_c;
    assign bus.stall_cycles   = stall_q;
endmodule
